relu_maxpool: RTL and testbench

Post-convolution stage that consumes the serial 22-bit signed convolution result stream (one result per `conv_valid` pulse, raster order) and applies ReLU, then 2x2 stride-2 max pooling. It requantizes each pooled value to a 9-bit signed word for the next layer's pixel inputs. It sits directly downstream of the 5x5 convolution unit: one instance per output channel, 28x28 map in, 14x14 map out.

---
 rtl/relu_maxpool.sv | 72 +++++++
 tb/tb_relu_maxpool.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool.sv
// relu_maxpool: ReLU followed by 2x2 stride-2 max pooling on a raster-order conv stream,
// with each pooled value requantized by an arithmetic shift and saturated to a signed output word.
module relu_maxpool #(
    parameter int DATA_W = 22,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int SHIFT  = 7,
    parameter int OUT_W  = 9
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     conv_valid,
    input  logic signed [DATA_W-1:0] conv_data,
    output logic                     pool_valid,
    output logic [OUT_W-1:0]         pool_data,
    output logic                     frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = DATA_W - 1;
    localparam int LD = IMG_W / 2;
    localparam logic [PW-1:0] SAT = PW'((1 << (OUT_W - 1)) - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] h, r, m, p, q;
    logic [PW-1:0] lb [LD];
    logic [CW-2:0] idx;
    logic col_last, row_last, fire, lb_we;

    // After ReLU every value is non-negative, so the sign bit is dropped everywhere downstream.
    always_comb begin
        r        = conv_data[DATA_W-1] ? '0 : conv_data[PW-1:0];
        m        = (r > h) ? r : h;
        idx      = col[CW-1:1];
        p        = (lb[idx] > m) ? lb[idx] : m;
        q        = p >> SHIFT;
        col_last = col == CW'(IMG_W - 1);
        row_last = row == RW'(IMG_H - 1);
        fire     = conv_valid && col[0] && row[0];
        lb_we    = conv_valid && col[0] && !row[0];
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            col        <= '0;
            row        <= '0;
            h          <= '0;
            pool_valid <= 1'b0;
            pool_data  <= '0;
            frame_done <= 1'b0;
        end else begin
            pool_valid <= fire;
            frame_done <= fire && col_last && row_last;
            if (fire)
                pool_data <= (q > SAT) ? OUT_W'(SAT) : OUT_W'(q);
            if (conv_valid) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last)
                    row <= row_last ? '0 : row + 1'b1;
                if (!col[0])
                    h <= r;
            end
        end
    end

    // Line buffer holds horizontal pair maxima of the even row; always rewritten before being read.
    always_ff @(posedge clk) begin
        if (!rstn && lb_we)
            lb[idx] <= m;
    end
endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: directed checks of relu_maxpool against hand-computed pooled values.
module tb_relu_maxpool;
    logic               clk = 1'b0;
    logic               rstn = 1'b1;
    logic               conv_valid = 1'b0;
    logic signed [21:0] conv_data = '0;
    logic               pool_valid;
    logic [8:0]         pool_data;
    logic               frame_done;

    int total = 0, bad = 0, cyc = 0, t11 = 0;
    logic [8:0] qd[$];
    bit         qf[$];
    int         qc[$];

    relu_maxpool dut (
        .clk(clk), .rstn(rstn), .conv_valid(conv_valid), .conv_data(conv_data),
        .pool_valid(pool_valid), .pool_data(pool_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (pool_valid) begin
        qd.push_back(pool_data);
        qf.push_back(frame_done);
        qc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int smp(input int k, input int r, input int c);
        case (k)
            0: return -5;
            1: return (r == 0 && c == 0) ? 128 : (r == 0 && c == 1) ? 640 :
                      (r == 1 && c == 0) ? -1000 : (r == 1 && c == 1) ? 384 : 0;
            2: return (r != 0) ? 0 : (c == 0) ? 2000000 : (c == 2) ? 32767 :
                      (c == 4) ? 32640 : (c == 6) ? 32639 : 0;
            3: return 128 * (r * 28 + c);
            default: return (r % 2 == 0) ? 128 * (r + c) : 0;
        endcase
    endfunction

    function automatic int gold(input int k, input int i, input int j);
        if (k == 3) return (56 * i + 2 * j + 29 > 255) ? 255 : 56 * i + 2 * j + 29;
        return 2 * i + 2 * j + 1;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            conv_valid = 1'b0;
        end
    endtask

    task automatic frame(input int k, input int gap, input int nmax = 784);
        int n = 0;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                if (n == nmax) return;
                @(negedge clk);
                conv_valid = 1'b1;
                conv_data  = 22'(smp(k, r, c));
                if (r == 1 && c == 1) t11 = cyc;
                n++;
                idle(gap);
            end
    endtask

    task automatic clr();
        qd.delete();
        qf.delete();
        qc.delete();
    endtask

    task automatic chk_frame(input int k, input int base);
        for (int n = 0; n < 196 && base + n < qd.size(); n++)
            chk($sformatf("k%0d_out%0d", k, n), 32'(qd[base + n]), gold(k, n / 14, n % 14));
    endtask

    task automatic rst_pulse(input string tag);
        @(negedge clk);
        rstn       = 1'b1;
        conv_valid = 1'b1;
        conv_data  = 22'(12345);
        @(negedge clk);
        rstn       = 1'b0;
        conv_valid = 1'b0;
        chk(tag, 32'(pool_valid), 0);
    endtask

    function automatic int fd_count();
        int s = 0;
        foreach (qf[n]) s += int'(qf[n]);
        return s;
    endfunction

    initial begin
        int s;
        repeat (2) @(negedge clk);
        chk("rst_pool_valid", 32'(pool_valid), 0);
        chk("rst_pool_data", 32'(pool_data), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        rstn = 1'b0;

        clr();
        frame(0, 0);
        idle(4);
        chk("relu_count", qd.size(), 196);
        s = 0;
        foreach (qd[n]) s += (qd[n] != 0) ? 1 : 0;
        chk("relu_nonzero", s, 0);
        chk("relu_fd_count", fd_count(), 1);
        if (qf.size() == 196) chk("relu_fd_last", 32'(qf[195]), 1);

        clr();
        frame(1, 0);
        idle(4);
        chk("max_count", qd.size(), 196);
        if (qd.size() >= 14) begin
            chk("max_first", 32'(qd[0]), 5);
            chk("max_latency", qc[0], t11 + 1);
            s = 0;
            for (int n = 1; n < 14; n++) s += int'(qd[n]);
            chk("max_rest_row0", s, 0);
        end

        clr();
        frame(2, 0);
        idle(4);
        chk("sat_count", qd.size(), 196);
        if (qd.size() >= 4) begin
            chk("sat_2000000", 32'(qd[0]), 255);
            chk("sat_32767", 32'(qd[1]), 255);
            chk("sat_32640", 32'(qd[2]), 255);
            chk("sat_32639", 32'(qd[3]), 254);
        end

        clr();
        frame(3, 7);
        idle(4);
        chk("gap_count", qd.size(), 196);
        chk_frame(3, 0);
        if (qd.size() == 196) begin
            chk("gap_space_0_1", qc[1] - qc[0], 16);
            chk("gap_space_12_13", qc[13] - qc[12], 16);
            chk("gap_fd_last", 32'(qf[195]), 1);
        end
        chk("gap_fd_count", fd_count(), 1);
        chk("gap_hold", 32'(pool_data), 255);

        frame(3, 0, 29);
        rst_pulse("rst_odd_no_valid");
        frame(3, 0, 300);
        rst_pulse("rst_mid_no_valid");
        clr();
        frame(3, 0);
        idle(4);
        chk("rst_count", qd.size(), 196);
        chk_frame(3, 0);
        chk("rst_fd_count", fd_count(), 1);

        clr();
        frame(3, 0);
        frame(4, 0);
        idle(4);
        chk("wrap_count", qd.size(), 392);
        chk("wrap_fd_count", fd_count(), 2);
        if (qd.size() == 392) begin
            chk("wrap_fd_196", 32'(qf[195]), 1);
            chk("wrap_fd_392", 32'(qf[391]), 1);
        end
        chk_frame(3, 0);
        chk_frame(4, 196);
        chk("wrap_hold", 32'(pool_data), 53);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
